single_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle CPU. Sits directly downstream of the general-purpose register file and consumes its two read-data outputs as operands.
Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. Exposes HI/LO for MFHI/MFLO writeback and a busy flag the control unit uses to stall.

---
 rtl/single_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_single_muldiv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : single_muldiv
// Description : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and
//               single-cycle MTHI/MTLO. Optional SINGLE_MULDIV_ABORT_EN adds
//               an i_abort input that cancels an in-flight operation.
// Revision    : 1.0 - initial release
// ============================================================================
module single_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
`ifdef SINGLE_MULDIV_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_b;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_is_div;
    logic                   r_done;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;

    logic                   w_abort;
    logic                   w_signed;
    logic                   w_s1;
    logic                   w_s2;
    logic [WIDTH-1:0]       w_abs1;
    logic [WIDTH-1:0]       w_abs2;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH:0]         w_diff;
    logic                   w_borrow;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_q_fix;
    logic [WIDTH-1:0]       w_r_fix;

`ifdef SINGLE_MULDIV_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Operand conditioning: signed ops work on magnitudes, signs fixed in S_FIX
    assign w_signed = ~i_op[0];
    assign w_s1     = w_signed & i_op1[WIDTH-1];
    assign w_s2     = w_signed & i_op2[WIDTH-1];
    assign w_abs1   = w_s1 ? (WIDTH'(0) - i_op1) : i_op1;
    assign w_abs2   = w_s2 ? (WIDTH'(0) - i_op2) : i_op2;

    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    assign w_shift  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_borrow = w_diff[WIDTH];

    assign w_prod_fix = r_neg_q ? ((2*WIDTH)'(0) - r_acc) : r_acc;
    assign w_q_fix    = r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_r_fix    = r_neg_r ? (WIDTH'(0) - r_acc[2*WIDTH-1:WIDTH])
                                : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_op[2]) begin
                    w_next = i_op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == C_LAST) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (!i_op[2]) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_abs1};
                            r_b      <= w_abs2;
                            r_cnt    <= '0;
                            r_is_div <= i_op[1];
                            r_neg_r  <= w_s1;
                            // Divide by zero: all-ones quotient kept as is,
                            // signed remainder then reproduces the dividend.
                            r_neg_q  <= (w_s1 ^ w_s2) & ~(i_op[1] && (i_op2 == '0));
                        end else if (i_op == 3'b100) begin
                            r_hi <= i_op1;
                        end else if (i_op == 3'b101) begin
                            r_lo <= i_op1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= {(w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                              r_acc[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!w_abort) begin
                        if (r_is_div) begin
                            r_lo <= w_q_fix;
                            r_hi <= w_r_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_single_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_single_muldiv
// Description : Directed and scoreboard-driven bench for single_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_push   = 0;

    single_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_op1   (i_op1),
        .i_op2   (i_op2),
`ifdef SINGLE_MULDIV_ABORT_EN
        .i_abort (i_abort),
`endif
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        int     ia;
        int     ib;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ia = a;
                ib = b;
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            exp_t e;
            n_done++;
            check("scoreboard_nonempty_at_done", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({"result_", e.tag}, {o_hi, o_lo}, {e.hi, e.lo});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] expv, input string tag);
        exp_t e;
        i_start = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        if (push) begin
            e.hi  = expv[63:32];
            e.lo  = expv[31:0];
            e.tag = tag;
            exp_q.push_back(e);
            n_push++;
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          done_snap;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst     = 1'b0;
        i_start = 1'b0;
        i_op    = 3'd0;
        i_op1   = '0;
        i_op2   = '0;
        i_abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hi",   {32'd0, o_hi}, 64'd0);
        check("reset_lo",   {32'd0, o_lo}, 64'd0);
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check("reset_done", {63'd0, o_done}, 64'd0);
        rst = 1'b1;

        // MTHI / MTLO on consecutive cycles
        issue(3'b100, 32'h1234_5678, 32'd0, 0, 64'd0, "mthi");
        check("mthi_hi",   {32'd0, o_hi}, 64'h1234_5678);
        check("mthi_busy", {63'd0, o_busy}, 64'd0);
        issue(3'b101, 32'h9ABC_DEF0, 32'd0, 0, 64'd0, "mtlo");
        check("mtlo_lo",   {32'd0, o_lo}, 64'h9ABC_DEF0);
        check("mtlo_hi",   {32'd0, o_hi}, 64'h1234_5678);
        check("mtlo_busy", {63'd0, o_busy}, 64'd0);

        // MULTU max x max: latency and single done pulse
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, "multu_max");
        wait_idle(n);
        check("multu_busy_cycles", 64'(n), 64'd33);
        check("multu_done_high",   {63'd0, o_done}, 64'd1);
        @(negedge clk);
        check("multu_done_pulse",  {63'd0, o_done}, 64'd0);

        // MULT then DIV accepted on the done cycle
        issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
        wait_idle(n);
        check("mult_done_cycle", {63'd0, o_done}, 64'd1);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
        check("div_no_gap_busy", {63'd0, o_busy}, 64'd1);
        wait_idle(n);
        check("div_busy_cycles", 64'(n), 64'd33);

        // Boundary cases
        issue(3'b011, 32'd100, 32'd0, 1, 64'h0000_0064_FFFF_FFFF, "divu_by0");
        wait_idle(n);
        issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1, 64'hFFFF_FFF9_FFFF_FFFF, "div_neg_by0");
        wait_idle(n);
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, "mult_min_min");
        wait_idle(n);
        issue(3'b010, 32'd7, 32'hFFFF_FFFE, 1, 64'h0000_0001_FFFF_FFFD, "div_7byneg2");
        wait_idle(n);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000, "div_overflow");
        wait_idle(n);

        // Start ignored while busy, operand changes ignored
        @(negedge clk);
        issue(3'b011, 32'd1000, 32'd7, 1, 64'h0000_0006_0000_008E, "divu_1000by7");
        repeat (9) @(negedge clk);
        i_start = 1'b1;
        i_op    = 3'b101;
        i_op1   = 32'h0000_DEAD;
        i_op2   = 32'd0;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_mtlo_ignored_lo", {32'd0, o_lo}, 64'h8000_0000);
        check("busy_mtlo_ignored_hi", {32'd0, o_hi}, 64'd0);
        wait_idle(n);
        check("divu_remaining_busy", 64'(n), 64'd23);

        // Reset mid-operation discards the result
        @(negedge clk);
        issue(3'b000, 32'd3, 32'd4, 0, 64'd0, "mult_reset");
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midreset_hi",   {32'd0, o_hi}, 64'd0);
        check("midreset_lo",   {32'd0, o_lo}, 64'd0);
        check("midreset_busy", {63'd0, o_busy}, 64'd0);
        done_snap = n_done;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 64'(n_done), 64'(done_snap));

        // Randomised back-to-back operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(rop, ra, rb, 1, model(rop, ra, rb), $sformatf("rand%0d", i));
            wait_idle(n);
        end

`ifdef SINGLE_MULDIV_ABORT_EN
        @(negedge clk);
        issue(3'b100, 32'h55, 32'd0, 0, 64'd0, "mthi55");
        issue(3'b000, 32'd3, 32'd4, 0, 64'd0, "mult_abort");
        repeat (4) @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_busy", {63'd0, o_busy}, 64'd0);
        check("abort_hi",   {32'd0, o_hi}, 64'h55);
        done_snap = n_done;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(n_done), 64'(done_snap));
        i_abort = 1'b1;
        issue(3'b101, 32'h77, 32'd0, 0, 64'd0, "mtlo_abort_idle");
        i_abort = 1'b0;
        check("abort_idle_ignored", {32'd0, o_lo}, 64'h77);
`endif

        @(negedge clk);
        check("total_done_pulses", 64'(n_done), 64'(n_push));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
